// File: rtl/ram32b_arbiter_if.sv
// Request/response and RAM-side signal bundle for the two-port RAM arbiter.
interface ram32b_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic        req0_write;
    logic [31:0] req0_addr;
    logic [31:0] req0_wdata;
    logic        req1_valid;
    logic        req1_ready;
    logic        req1_write;
    logic [31:0] req1_addr;
    logic [31:0] req1_wdata;
    logic        resp0_valid;
    logic        resp1_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic [31:0] mem_address;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        input  mem_read_data,
        output req0_ready, req1_ready, resp0_valid, resp1_valid,
        output resp_rdata, resp_err, busy,
        output mem_address, mem_read_enable, mem_write_enable, mem_write_data
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        output mem_read_data,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid,
        input  resp_rdata, resp_err, busy,
        input  mem_address, mem_read_enable, mem_write_enable, mem_write_data
    );
endinterface

// File: rtl/ram32b_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a shared single-port 32-bit RAM.
// One request in flight; alignment/range checked before any RAM access is issued.
module ram32b_arbiter #(
    parameter int unsigned MEM_BYTES    = 4096,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ALIGN_CHECK  = 1
) (
    input  logic             clk,
    input  logic             rst,
    ram32b_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W   = 3;
    localparam logic [31:0] LAST_OK = 32'(MEM_BYTES - 4);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(READ_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_last_grant;
    logic             r_port;
    logic             r_write;

    logic             r_mem_re, r_mem_we;
    logic [31:0]      r_mem_addr, r_mem_wdata;
    logic             r_resp0, r_resp1, r_resp_err, r_busy;
    logic [31:0]      r_resp_rdata;

    logic             w_grant, w_ready0, w_ready1, w_hs;
    logic             w_sel_write, w_req_err;
    logic [31:0]      w_sel_addr, w_sel_wdata;
    logic             w_issue, w_resp, w_resp_port, w_resp_err, w_sample;

    // Grant: a lone requester wins; on contention the port not served last wins.
    always_comb begin
        w_grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) w_grant = ~r_last_grant;
        else if (bus.req1_valid)              w_grant = 1'b1;
        w_ready0    = (r_state == S_IDLE) && !w_grant && bus.req0_valid;
        w_ready1    = (r_state == S_IDLE) &&  w_grant && bus.req1_valid;
        w_hs        = w_ready0 | w_ready1;
        w_sel_write = w_grant ? bus.req1_write : bus.req0_write;
        w_sel_addr  = w_grant ? bus.req1_addr  : bus.req0_addr;
        w_sel_wdata = w_grant ? bus.req1_wdata : bus.req0_wdata;
        w_req_err   = ((ALIGN_CHECK != 0) && (w_sel_addr[1:0] != 2'b00))
                    || (w_sel_addr > LAST_OK);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_issue     = 1'b0;
        w_resp      = 1'b0;
        w_resp_port = r_port;
        w_resp_err  = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    if (w_req_err) begin
                        w_state_nxt = S_RESP;
                        w_resp      = 1'b1;
                        w_resp_port = w_grant;
                        w_resp_err  = 1'b1;
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_issue     = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (r_write) begin
                    w_state_nxt = S_RESP;
                    w_resp      = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = LAT;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                // Count of 1 is the cycle the RAM data is valid; <=1 also guards a zero load.
                if (r_cnt <= CNT_W'(1)) begin
                    w_sample    = 1'b1;
                    w_state_nxt = S_RESP;
                    w_resp      = 1'b1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_write      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_hs) begin
                r_last_grant <= w_grant;
                r_port       <= w_grant;
                r_write      <= w_sel_write;
            end
        end
    end

    // Outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_resp0      <= 1'b0;
            r_resp1      <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_mem_re   <= w_issue & ~w_sel_write;
            r_mem_we   <= w_issue &  w_sel_write;
            r_resp0    <= w_resp  & ~w_resp_port;
            r_resp1    <= w_resp  &  w_resp_port;
            r_resp_err <= w_resp_err;
            r_busy     <= (w_state_nxt != S_IDLE);
            if (w_issue)               r_mem_addr   <= w_sel_addr;
            if (w_issue && w_sel_write) r_mem_wdata <= w_sel_wdata;
            if (w_sample)              r_resp_rdata <= bus.mem_read_data;
        end
    end

    assign bus.req0_ready       = w_ready0;
    assign bus.req1_ready       = w_ready1;
    assign bus.resp0_valid      = r_resp0;
    assign bus.resp1_valid      = r_resp1;
    assign bus.resp_rdata       = r_resp_rdata;
    assign bus.resp_err         = r_resp_err;
    assign bus.busy             = r_busy;
    assign bus.mem_address      = r_mem_addr;
    assign bus.mem_read_enable  = r_mem_re;
    assign bus.mem_write_enable = r_mem_we;
    assign bus.mem_write_data   = r_mem_wdata;

endmodule
